bash_cmd_sched: RTL and testbench

Command scheduler between the terminal video block and the command-execution units. It captures each entered command line over the terminal's line-out handshake and offers it to `N_UNITS` command units. It grants the line to exactly one claiming unit, buffers that unit's reply bytes, and streams them back over the terminal's line-in handshake. It then closes the command with the solved/acknowledge pulse pair, which re-arms keyboard input.

---
 rtl/bash_pkg.sv | 29 ++
 rtl/bash_cmd_sched_if.sv | 38 +++
 rtl/bash_resp_fifo.sv | 46 ++++
 rtl/bash_cmd_sched.sv | 163 ++++++++++++++++
 tb/tb_bash_cmd_sched.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bash_pkg.sv
// Shared types and constants for the bash command scheduler.
package bash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DISPATCH,
    ST_RUN,
    ST_FLUSH,
    ST_SOLVE,
    ST_WAIT_ACK
  } sched_state_t;

  localparam int         BASH_MAX_LEN = 32;
  localparam logic [7:0] BASH_EOL     = 8'h00;
  localparam logic [7:0] BASH_ERR_E   = 8'h45;
  localparam logic [7:0] BASH_ERR_R   = 8'h52;

  // Reply sent when no unit claims the command: "ERR" plus terminator.
  function automatic logic [7:0] err_byte(input logic [1:0] i);
    case (i)
      2'd0:    return BASH_ERR_E;
      2'd1:    return BASH_ERR_R;
      2'd2:    return BASH_ERR_R;
      default: return BASH_EOL;
    endcase
  endfunction

endpackage

// File: rtl/bash_cmd_sched_if.sv
// Terminal and command-unit signals of the scheduler; master is the scheduler side.
interface bash_cmd_sched_if #(
  parameter int N_UNITS = 4
);
  logic               term_out_ready;
  logic [5:0]         term_out_len;
  logic [7:0]         term_line_out;
  logic               term_out_next;
  logic               term_in_ready;
  logic [7:0]         term_line_in;
  logic               term_in_next;
  logic               term_solved;
  logic               term_solved_ack;
  logic               cmd_valid;
  logic [5:0]         cmd_len;
  logic [4:0]         cmd_rd_addr;
  logic [7:0]         cmd_rd_data;
  logic [N_UNITS-1:0] claim;
  logic [N_UNITS-1:0] grant;
  logic               resp_valid;
  logic [7:0]         resp_data;
  logic               resp_ready;
  logic [N_UNITS-1:0] done;

  modport master (
    input  term_out_ready, term_out_len, term_line_out, term_in_next, term_solved_ack,
    input  cmd_rd_addr, claim, resp_valid, resp_data, done,
    output term_out_next, term_in_ready, term_line_in, term_solved,
    output cmd_valid, cmd_len, cmd_rd_data, grant, resp_ready
  );

  modport slave (
    output term_out_ready, term_out_len, term_line_out, term_in_next, term_solved_ack,
    output cmd_rd_addr, claim, resp_valid, resp_data, done,
    input  term_out_next, term_in_ready, term_line_in, term_solved,
    input  cmd_valid, cmd_len, cmd_rd_data, grant, resp_ready
  );
endinterface

// File: rtl/bash_resp_fifo.sv
// Reply byte FIFO; registered storage, head visible combinationally.
module bash_resp_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/bash_cmd_sched.sv
// Captures a terminal command line, hands it to one claiming unit and streams the reply back.
//   state       | meaning
//   ST_IDLE     | waiting for a command line from the terminal
//   ST_CAPTURE  | copying bytes, phase A takes a byte, phase B lets the terminal advance
//   ST_DISPATCH | offering the command; on timeout pushes "ERR",0 itself
//   ST_RUN      | unit granted, reply bytes buffered and drained
//   ST_FLUSH    | draining the remaining reply bytes
//   ST_SOLVE    | term_solved pulse
//   ST_WAIT_ACK | waiting for the terminal to restore the prompt
module bash_cmd_sched
  import bash_pkg::*;
#(
  parameter int N_UNITS       = 4,
  parameter int MAX_LEN       = BASH_MAX_LEN,
  parameter int FIFO_DEPTH    = 16,
  parameter int CLAIM_TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  bash_cmd_sched_if.master  bus
);
  localparam logic [5:0] MAX_LEN_W  = 6'(MAX_LEN);
  localparam logic [7:0] TIMEOUT_W  = 8'(CLAIM_TIMEOUT);

  sched_state_t       state;
  logic [5:0]         len, idx, idx_inc;
  logic               phase_b;
  logic [7:0]         to_cnt;
  logic               err_act;
  logic [1:0]         err_idx;
  logic [7:0]         cmd_buf [MAX_LEN];
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]         fifo_wdata, fifo_rdata;
  logic               drain_en, buf_we;
  logic [N_UNITS-1:0] claim_pick;

  assign idx_inc          = idx + 6'd1;
  assign claim_pick       = bus.claim & (-bus.claim);
  assign drain_en         = (state == ST_RUN) || (state == ST_FLUSH);
  assign bus.term_in_ready = drain_en && !fifo_empty;
  assign bus.term_line_in  = bus.term_in_ready ? fifo_rdata : 8'h00;
  assign bus.resp_ready    = (state == ST_RUN) && !fifo_full;
  assign fifo_pop          = bus.term_in_next && bus.term_in_ready;
  assign fifo_push         = ((state == ST_RUN) && bus.resp_valid && bus.resp_ready)
                           || ((state == ST_DISPATCH) && err_act);
  assign fifo_wdata        = err_act ? err_byte(err_idx) : bus.resp_data;
  assign buf_we            = (state == ST_CAPTURE) && !phase_b && bus.term_out_ready
                           && (idx < MAX_LEN_W);
  assign bus.cmd_rd_data   = cmd_buf[bus.cmd_rd_addr];

  always_ff @(posedge clk) begin
    if (buf_we) cmd_buf[idx[4:0]] <= bus.term_line_out;
  end

  bash_resp_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      len               <= '0;
      idx               <= '0;
      phase_b           <= 1'b0;
      to_cnt            <= '0;
      err_act           <= 1'b0;
      err_idx           <= '0;
      bus.term_out_next <= 1'b0;
      bus.term_solved   <= 1'b0;
      bus.cmd_valid     <= 1'b0;
      bus.cmd_len       <= '0;
      bus.grant         <= '0;
    end else begin
      bus.term_out_next <= 1'b0;
      bus.term_solved   <= 1'b0;
      case (state)
        ST_IDLE: begin
          err_act <= 1'b0;
          if (bus.term_out_ready) begin
            len     <= bus.term_out_len;
            idx     <= '0;
            phase_b <= 1'b0;
            if (bus.term_out_len == '0) begin
              state           <= ST_SOLVE;
              bus.term_solved <= 1'b1;
            end else begin
              state             <= ST_CAPTURE;
              bus.term_out_next <= 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          if (!phase_b) begin
            if (bus.term_out_ready) begin
              phase_b <= 1'b1;
            end else if (idx == '0) begin
              state           <= ST_SOLVE;
              bus.term_solved <= 1'b1;
            end else begin
              state         <= ST_DISPATCH;
              bus.cmd_valid <= 1'b1;
              bus.cmd_len   <= idx;
              to_cnt        <= '0;
            end
          end else begin
            phase_b <= 1'b0;
            idx     <= idx_inc;
            if (idx_inc == len) begin
              state         <= ST_DISPATCH;
              bus.cmd_valid <= 1'b1;
              bus.cmd_len   <= len;
              to_cnt        <= '0;
            end else begin
              bus.term_out_next <= 1'b1;
            end
          end
        end
        ST_DISPATCH: begin
          if (err_act) begin
            err_idx <= err_idx + 2'd1;
            if (err_idx == 2'd3) begin
              err_act <= 1'b0;
              state   <= ST_FLUSH;
            end
          end else if (|bus.claim) begin
            bus.grant <= claim_pick;
            state     <= ST_RUN;
          end else if (to_cnt != 8'hFF) begin
            to_cnt <= to_cnt + 8'd1;
            if (to_cnt == TIMEOUT_W - 8'd1) begin
              err_act       <= 1'b1;
              err_idx       <= '0;
              bus.cmd_valid <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (|(bus.done & bus.grant)) begin
            bus.grant     <= '0;
            bus.cmd_valid <= 1'b0;
            state         <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (fifo_empty) begin
            state           <= ST_SOLVE;
            bus.term_solved <= 1'b1;
          end
        end
        ST_SOLVE:    state <= ST_WAIT_ACK;
        ST_WAIT_ACK: if (bus.term_solved_ack) state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bash_cmd_sched.sv
// Directed bench for bash_cmd_sched: bench acts as terminal and command units.
module tb_bash_cmd_sched;
  import bash_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bash_cmd_sched_if #(.N_UNITS(4)) bus ();

  bash_cmd_sched #(
    .N_UNITS(4), .MAX_LEN(32), .FIFO_DEPTH(16), .CLAIM_TIMEOUT(15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] cmd_bytes [32];
  logic [7:0] rx [32];
  int rx_cnt;

  // Terminal side of the line-out handshake; returns number of next pulses and first-pulse latency.
  task automatic term_send(input int n, output int nexts, output int first_lat);
    int ptr;
    bit seen;
    ptr = 0; seen = 0; nexts = 0; first_lat = -1;
    bus.term_out_len   = 6'(n);
    bus.term_line_out  = cmd_bytes[0];
    bus.term_out_ready = 1'b1;
    for (int c = 1; c < 4 * n + 20 && ptr < n; c++) begin
      @(negedge clk);
      if (bus.term_out_next) begin
        if (first_lat < 0) first_lat = c;
        nexts++;
        seen = 1;
      end else if (seen) begin
        seen = 0;
        ptr++;
        if (ptr < 32) bus.term_line_out = cmd_bytes[ptr];
      end
    end
    bus.term_out_ready = 1'b0;
  endtask

  task automatic wait_cmd_valid(output int cyc);
    cyc = -1;
    for (int c = 1; c <= 50 && cyc < 0; c++) begin
      @(negedge clk);
      if (bus.cmd_valid) cyc = c;
    end
  endtask

  task automatic term_recv(input int n);
    rx_cnt = 0;
    for (int c = 0; c < 200 && rx_cnt < n; c++) begin
      if (bus.term_in_ready) begin
        rx[rx_cnt] = bus.term_line_in;
        rx_cnt++;
        bus.term_in_next = 1'b1;
      end else begin
        bus.term_in_next = 1'b0;
      end
      @(negedge clk);
    end
    bus.term_in_next = 1'b0;
  endtask

  // Waits for term_solved, measures its width, then acknowledges.
  task automatic wait_solved(output int cyc, output int width);
    cyc = -1; width = 0;
    for (int c = 1; c <= 60 && cyc < 0; c++) begin
      @(negedge clk);
      if (bus.term_solved) cyc = c;
    end
    if (cyc >= 0) begin
      width = 1;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (bus.term_solved) width++;
        else break;
      end
    end
    bus.term_solved_ack = 1'b1;
    @(negedge clk);
    bus.term_solved_ack = 1'b0;
  endtask

  task automatic unit_push(input logic [7:0] b);
    bus.resp_valid = 1'b1;
    bus.resp_data  = b;
    @(negedge clk);
    bus.resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus.term_out_next !== 1'b0) begin n_bad++; $display("FAIL rst_out_next: got %b want 0", bus.term_out_next); end
    n_cmp++; if (bus.term_in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", bus.term_in_ready); end
    n_cmp++; if (bus.term_line_in !== 8'h00) begin n_bad++; $display("FAIL rst_line_in: got %h want 00", bus.term_line_in); end
    n_cmp++; if (bus.term_solved !== 1'b0) begin n_bad++; $display("FAIL rst_solved: got %b want 0", bus.term_solved); end
    n_cmp++; if (bus.cmd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_valid: got %b want 0", bus.cmd_valid); end
    n_cmp++; if (bus.cmd_len !== 6'd0) begin n_bad++; $display("FAIL rst_cmd_len: got %0d want 0", bus.cmd_len); end
    n_cmp++; if (bus.grant !== 4'b0000) begin n_bad++; $display("FAIL rst_grant: got %b want 0000", bus.grant); end
    n_cmp++; if (bus.resp_ready !== 1'b0) begin n_bad++; $display("FAIL rst_resp_ready: got %b want 0", bus.resp_ready); end
    n_cmp++; if (dut.state !== ST_IDLE) begin n_bad++; $display("FAIL rst_state: got %0d want %0d", dut.state, ST_IDLE); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ls();
    int nexts, lat, cyc, w;
    cmd_bytes[0] = 8'h6c; cmd_bytes[1] = 8'h73;
    term_send(2, nexts, lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL ls_next_latency: got %0d want 1", lat); end
    n_cmp++; if (nexts !== 2) begin n_bad++; $display("FAIL ls_next_count: got %0d want 2", nexts); end
    wait_cmd_valid(cyc);
    n_cmp++; if (cyc < 0) begin n_bad++; $display("FAIL ls_cmd_valid: got timeout want asserted"); end
    n_cmp++; if (bus.cmd_len !== 6'd2) begin n_bad++; $display("FAIL ls_cmd_len: got %0d want 2", bus.cmd_len); end
    bus.cmd_rd_addr = 5'd0; #1;
    n_cmp++; if (bus.cmd_rd_data !== 8'h6c) begin n_bad++; $display("FAIL ls_buf0: got %h want 6c", bus.cmd_rd_data); end
    bus.cmd_rd_addr = 5'd1; #1;
    n_cmp++; if (bus.cmd_rd_data !== 8'h73) begin n_bad++; $display("FAIL ls_buf1: got %h want 73", bus.cmd_rd_data); end
    bus.claim = 4'b0010;
    @(negedge clk);
    bus.claim = 4'b0000;
    n_cmp++; if (bus.grant !== 4'b0010) begin n_bad++; $display("FAIL ls_grant: got %b want 0010", bus.grant); end
    unit_push(8'h61);
    n_cmp++; if (bus.term_line_in !== 8'h61 || bus.term_in_ready !== 1'b1) begin n_bad++; $display("FAIL ls_head: got %h/%b want 61/1", bus.term_line_in, bus.term_in_ready); end
    unit_push(8'h00);
    bus.done = 4'b0010;
    @(negedge clk);
    bus.done = 4'b0000;
    n_cmp++; if (bus.grant !== 4'b0000 || bus.cmd_valid !== 1'b0) begin n_bad++; $display("FAIL ls_release: got grant %b valid %b want 0000 0", bus.grant, bus.cmd_valid); end
    term_recv(2);
    n_cmp++; if (rx_cnt !== 2 || rx[0] !== 8'h61 || rx[1] !== 8'h00) begin n_bad++; $display("FAIL ls_reply: got %0d bytes %h %h want 2 bytes 61 00", rx_cnt, rx[0], rx[1]); end
    wait_solved(cyc, w);
    n_cmp++; if (cyc < 0) begin n_bad++; $display("FAIL ls_solved: got timeout want pulse"); end
    n_cmp++; if (w !== 1) begin n_bad++; $display("FAIL ls_solved_width: got %0d want 1", w); end
    n_cmp++; if (dut.state !== ST_IDLE) begin n_bad++; $display("FAIL ls_idle: got %0d want %0d", dut.state, ST_IDLE); end
  endtask

  task automatic test_tie();
    int nexts, lat, cyc, w;
    bus.claim = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    bus.claim = 4'b0000;
    n_cmp++; if (bus.grant !== 4'b0000) begin n_bad++; $display("FAIL idle_claim_ignored: got %b want 0000", bus.grant); end
    cmd_bytes[0] = 8'h79;
    term_send(1, nexts, lat);
    wait_cmd_valid(cyc);
    n_cmp++; if (cyc < 0) begin n_bad++; $display("FAIL tie_cmd_valid: got timeout want asserted"); end
    bus.claim = 4'b1100;
    @(negedge clk);
    bus.claim = 4'b0000;
    n_cmp++; if (bus.grant !== 4'b0100) begin n_bad++; $display("FAIL tie_grant: got %b want 0100", bus.grant); end
    bus.done = 4'b1000;
    @(negedge clk);
    n_cmp++; if (bus.grant !== 4'b0100) begin n_bad++; $display("FAIL tie_other_done: got %b want 0100", bus.grant); end
    bus.done = 4'b0100;
    @(negedge clk);
    bus.done = 4'b0000;
    wait_solved(cyc, w);
    n_cmp++; if (cyc < 0 || w !== 1) begin n_bad++; $display("FAIL tie_solved: got cyc %0d width %0d want pulse width 1", cyc, w); end
  endtask

  task automatic test_empty_line();
    bit saw_valid, saw_in, saw_next;
    int solved_at;
    saw_valid = 0; saw_in = 0; saw_next = 0; solved_at = -1;
    bus.term_out_len   = 6'd0;
    bus.term_out_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus.term_out_ready = 1'b0;
      if (bus.cmd_valid) saw_valid = 1;
      if (bus.term_in_ready) saw_in = 1;
      if (bus.term_out_next) saw_next = 1;
      if (bus.term_solved && solved_at < 0) solved_at = c;
    end
    n_cmp++; if (saw_valid || saw_in || saw_next) begin n_bad++; $display("FAIL empty_quiet: got valid %b in_ready %b out_next %b want 0 0 0", saw_valid, saw_in, saw_next); end
    n_cmp++; if (solved_at < 0) begin n_bad++; $display("FAIL empty_solved: got none want pulse within 3 cycles"); end
    bus.term_solved_ack = 1'b1;
    @(negedge clk);
    bus.term_solved_ack = 1'b0;
    n_cmp++; if (dut.state !== ST_IDLE) begin n_bad++; $display("FAIL empty_idle: got %0d want %0d", dut.state, ST_IDLE); end
  endtask

  task automatic test_timeout();
    int nexts, lat, cyc, w, hi;
    cmd_bytes[0] = 8'h78;
    term_send(1, nexts, lat);
    wait_cmd_valid(cyc);
    hi = (cyc < 0) ? 0 : 1;
    for (int c = 0; c < 40 && hi > 0; c++) begin
      @(negedge clk);
      if (bus.cmd_valid) hi++;
      else break;
    end
    n_cmp++; if (hi !== 15) begin n_bad++; $display("FAIL to_wait_cycles: got %0d want 15", hi); end
    term_recv(4);
    n_cmp++; if (rx_cnt !== 4 || rx[0] !== 8'h45 || rx[1] !== 8'h52 || rx[2] !== 8'h52 || rx[3] !== 8'h00)
      begin n_bad++; $display("FAIL to_err_bytes: got %0d bytes %h %h %h %h want 45 52 52 00", rx_cnt, rx[0], rx[1], rx[2], rx[3]); end
    wait_solved(cyc, w);
    n_cmp++; if (cyc < 0 || w !== 1) begin n_bad++; $display("FAIL to_solved: got cyc %0d width %0d want pulse width 1", cyc, w); end
  endtask

  task automatic test_back_to_back();
    int nexts, lat, cyc, w, sent;
    bit order_ok;
    cmd_bytes[0] = 8'h73;
    term_send(1, nexts, lat);
    wait_cmd_valid(cyc);
    bus.claim = 4'b0001;
    @(negedge clk);
    bus.claim = 4'b0000;
    n_cmp++; if (bus.grant !== 4'b0001) begin n_bad++; $display("FAIL bb_grant: got %b want 0001", bus.grant); end
    sent = 0;
    for (int c = 0; c < 16; c++) begin
      if (bus.resp_ready) begin
        bus.resp_valid = 1'b1;
        bus.resp_data  = 8'h10 + 8'(sent);
        sent++;
      end else begin
        bus.resp_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.resp_valid = 1'b0;
    n_cmp++; if (sent !== 16 || bus.resp_ready !== 1'b0) begin n_bad++; $display("FAIL bb_full: got %0d pushed ready %b want 16 pushed ready 0", sent, bus.resp_ready); end
    n_cmp++; if (bus.term_line_in !== 8'h10) begin n_bad++; $display("FAIL bb_head: got %h want 10", bus.term_line_in); end
    rx_cnt = 0;
    for (int c = 0; c < 200 && rx_cnt < 20; c++) begin
      if (bus.term_in_ready) begin
        rx[rx_cnt] = bus.term_line_in;
        rx_cnt++;
        bus.term_in_next = 1'b1;
      end else begin
        bus.term_in_next = 1'b0;
      end
      if (sent < 20 && bus.resp_ready) begin
        bus.resp_valid = 1'b1;
        bus.resp_data  = 8'h10 + 8'(sent);
        sent++;
      end else begin
        bus.resp_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.term_in_next = 1'b0;
    bus.resp_valid   = 1'b0;
    order_ok = (rx_cnt == 20);
    for (int i = 0; i < 20 && i < rx_cnt; i++) if (rx[i] !== 8'h10 + 8'(i)) order_ok = 0;
    n_cmp++; if (!order_ok) begin n_bad++; $display("FAIL bb_order: got %0d bytes first %h last %h want 20 bytes 10..23", rx_cnt, rx[0], rx[19]); end
    bus.done = 4'b0001;
    @(negedge clk);
    bus.done = 4'b0000;
    wait_solved(cyc, w);
    n_cmp++; if (cyc < 0 || w !== 1) begin n_bad++; $display("FAIL bb_solved: got cyc %0d width %0d want pulse width 1", cyc, w); end
  endtask

  task automatic test_reset_run();
    int nexts, lat, cyc;
    cmd_bytes[0] = 8'h72;
    term_send(1, nexts, lat);
    wait_cmd_valid(cyc);
    bus.claim = 4'b0001;
    @(negedge clk);
    bus.claim = 4'b0000;
    unit_push(8'hAA);
    unit_push(8'hBB);
    n_cmp++; if (bus.term_in_ready !== 1'b1 || bus.grant !== 4'b0001) begin n_bad++; $display("FAIL rr_pre: got in_ready %b grant %b want 1 0001", bus.term_in_ready, bus.grant); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.grant !== 4'b0000 || bus.cmd_valid !== 1'b0 || bus.cmd_len !== 6'd0 || bus.resp_ready !== 1'b0)
      begin n_bad++; $display("FAIL rr_unit_side: got grant %b valid %b len %0d ready %b want 0000 0 0 0", bus.grant, bus.cmd_valid, bus.cmd_len, bus.resp_ready); end
    n_cmp++; if (bus.term_in_ready !== 1'b0 || bus.term_line_in !== 8'h00 || bus.term_solved !== 1'b0 || bus.term_out_next !== 1'b0)
      begin n_bad++; $display("FAIL rr_term_side: got in_ready %b line %h solved %b next %b want 0 00 0 0", bus.term_in_ready, bus.term_line_in, bus.term_solved, bus.term_out_next); end
    n_cmp++; if (dut.fifo_empty !== 1'b1 || dut.state !== ST_IDLE) begin n_bad++; $display("FAIL rr_fifo_state: got empty %b state %0d want 1 %0d", dut.fifo_empty, dut.state, ST_IDLE); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.term_out_ready  = 1'b0;
    bus.term_out_len    = '0;
    bus.term_line_out   = '0;
    bus.term_in_next    = 1'b0;
    bus.term_solved_ack = 1'b0;
    bus.cmd_rd_addr     = '0;
    bus.claim           = '0;
    bus.resp_valid      = 1'b0;
    bus.resp_data       = '0;
    bus.done            = '0;
    for (int i = 0; i < 32; i++) begin
      cmd_bytes[i] = 8'h00;
      rx[i]        = 8'h00;
    end
    test_reset();
    test_ls();
    test_tie();
    test_empty_line();
    test_timeout();
    test_back_to_back();
    test_reset_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
